seg7_frame_decoder: RTL and testbench
=====================================

Name: seg7_frame_decoder

Overview:
Recovers BCD digits from a multiplexed, active-low 7-segment display bus (an_in digit strobes plus shared seg_in lines) and returns them to the datapath as whole frames. This is the inverse of the team's BCD-to-segment encoder and uses the same segment mapping: seg[6]=a … seg[0]=g, with 0 meaning lit. It is used as a loopback checker and display sniffer. Inputs are deglitched by a stability counter, decoded, assembled into a DIGITS-wide frame, and presented on a valid/ready output.

Parameters:
DIGITS, 4, number of multiplexed digits (an_in width); legal range 1..8
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; legal range 2..255

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
seg_in  input  7  segment lines, active-low, [6]=a … [0]=g
an_in  input  DIGITS  digit strobes, active-low; an_in[i]=0 selects digit i
digits_out  output  4*DIGITS  decoded frame; digit i at [4i+3:4i]
digit_err  output  DIGITS  per-digit flag: pattern was not a legal glyph
out_valid  output  1  frame available
out_ready  input  1  consumer accepts frame
overrun  output  1  sticky: a completed frame was dropped

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; there is no asynchronous path.
- Reset (rst_n=0 at an edge) clears:
  - outputs: digits_out=0, digit_err=0, out_valid=0, overrun=0
  - internal: sample register, stability counter, capture mask, shadow buffer
- Reset mid-frame discards partial captures. Reset wins over every other event on the same edge.
- Sampling:
  - Each edge, s_q <= {an_in, seg_in}.
  - If {an_in, seg_in} != s_q, cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Capture strobe:
  - Fires on the edge where cnt moves from STABLE_CYCLES-1 to STABLE_CYCLES, and only if an_in has exactly one bit low.
  - One capture per stable run. An input held for STABLE_CYCLES+1 consecutive edges captures on the last of those edges.
  - Glitches shorter than that are ignored.
  - an_in all-high or multi-low never captures.
- Decode table (seg -> code, err):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9
  - 1111111 (blank) -> 4'hF, err=0
  - any other pattern -> 4'hE, err=1
- Capture writes the code and err into shadow slot i and sets mask[i].
  - Recapturing a digit before the frame completes overwrites slot i; the newest value wins.
- Frame complete: occurs on the capture edge that makes mask all-ones.
  - If out_valid=0, or out_valid=1 with out_ready=1 on that edge, digits_out/digit_err load from the shadow buffer (including the slot being written that edge) and out_valid=1. Latency is 0 cycles from the final capture edge.
  - Otherwise the frame is dropped and overrun<=1.
  - mask clears in both cases.
- Handshake:
  - Transfer happens on an edge with out_valid=1 and out_ready=1.
  - out_valid deasserts after the transfer unless a new frame loads on the same edge.
  - digits_out and digit_err are held stable while out_valid=1 and out_ready=0.
  - out_ready is ignored while out_valid=0.
- overrun clears only on reset.
- Scan order is not required; frames complete whenever all DIGITS slots have been captured since the last completion.

Test Plan:
- Reset, DIGITS=4, STABLE_CYCLES=4: hold rst_n=0 for 3 edges with random inputs -> all outputs 0. Release -> out_valid stays 0 until four digits are captured.
- Drive digits 0..3 = 1,2,3,4 (an_in=1110/1101/1011/0111, seg=1001111/0010010/0000110/1001100), 6 cycles each, out_ready=1 -> out_valid pulses 1 cycle on the 4th capture edge. digits_out=16'h4321, digit_err=0.
- Glitch: digit 0 = 8 for 3 cycles then 5 for 6 cycles, rest of frame valid -> slot 0 = 5, never 8. Also drive an_in=1100 for 10 cycles -> no capture.
- Blank and illegal patterns: digit 1 seg=1111111, digit 2 seg=1010101 -> digits_out[7:4]=F, [11:8]=E, digit_err=4'b0100.
- Backpressure: out_ready=0, complete two frames (1234 then 5678) -> digits_out stays 16'h4321, overrun=1. Then out_ready=1 for 1 cycle -> out_valid=0 and overrun still 1.
- Reset mid-frame: capture digits 0–2, pulse rst_n low, then capture only digit 3 -> out_valid stays 0. Full rescan -> valid frame is delivered.

Source files
------------

// File: rtl/seg7_frame_decoder.sv
// Multiplexed 7-segment bus sniffer: deglitches the bus, decodes each strobed digit
// back to BCD and presents every complete DIGITS-wide frame on a valid/ready output.
module seg7_frame_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int unsigned SW = DIGITS + 7;

  logic [SW-1:0]          s_q;
  logic [7:0]             cnt;
  logic [DIGITS-1:0]      mask;
  logic [4*DIGITS-1:0]    sh_code;
  logic [DIGITS-1:0]      sh_err;

  logic [SW-1:0]          sample;
  logic                   stable;
  logic [DIGITS-1:0]      sel;
  logic                   cap;
  logic [3:0]             code;
  logic                   err;
  logic [4*DIGITS-1:0]    sh_code_nxt;
  logic [DIGITS-1:0]      sh_err_nxt;
  logic [DIGITS-1:0]      mask_nxt;
  logic                   frame_done;

  assign sample = {an_in, seg_in};
  assign stable = (sample == s_q);
  assign sel    = ~an_in;
  // Fires exactly once per stable run: the edge where the counter reaches its ceiling.
  assign cap    = stable && (cnt == 8'(STABLE_CYCLES - 1)) && $onehot(sel);

  always_comb begin
    code = 4'hE;
    err  = 1'b1;
    unique case (seg_in)
      7'b0000001: begin code = 4'd0; err = 1'b0; end
      7'b1001111: begin code = 4'd1; err = 1'b0; end
      7'b0010010: begin code = 4'd2; err = 1'b0; end
      7'b0000110: begin code = 4'd3; err = 1'b0; end
      7'b1001100: begin code = 4'd4; err = 1'b0; end
      7'b0100100: begin code = 4'd5; err = 1'b0; end
      7'b0100000: begin code = 4'd6; err = 1'b0; end
      7'b0001111: begin code = 4'd7; err = 1'b0; end
      7'b0000000: begin code = 4'd8; err = 1'b0; end
      7'b0000100: begin code = 4'd9; err = 1'b0; end
      7'b1111111: begin code = 4'hF; err = 1'b0; end
      default:    begin code = 4'hE; err = 1'b1; end
    endcase
  end

  // Shadow buffer including this edge's write, so a completing frame loads with zero latency.
  always_comb begin
    sh_code_nxt = sh_code;
    sh_err_nxt  = sh_err;
    mask_nxt    = mask;
    if (cap) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (sel[i]) begin
          sh_code_nxt[4*i +: 4] = code;
          sh_err_nxt[i]         = err;
          mask_nxt[i]           = 1'b1;
        end
      end
    end
    frame_done = cap && (&mask_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q        <= '0;
      cnt        <= '0;
      mask       <= '0;
      sh_code    <= '0;
      sh_err     <= '0;
      digits_out <= '0;
      digit_err  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s_q <= sample;
      if (!stable)
        cnt <= '0;
      else if (cnt != 8'(STABLE_CYCLES))
        cnt <= cnt + 8'd1;

      sh_code <= sh_code_nxt;
      sh_err  <= sh_err_nxt;
      mask    <= frame_done ? '0 : mask_nxt;

      if (frame_done) begin
        if (!out_valid || out_ready) begin
          digits_out <= sh_code_nxt;
          digit_err  <= sh_err_nxt;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed plus randomized bench for seg7_frame_decoder, checked against a
// history-based behavioural model of the display bus.
module tb_seg7_frame_decoder;

  localparam int unsigned D = 4;
  localparam int unsigned S = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [D-1:0]  an_in;
  logic [4*D-1:0] digits_out;
  logic [D-1:0]  digit_err;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;

  seg7_frame_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .digits_out (digits_out),
    .digit_err  (digit_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Model state: raw sample history since reset, per-slot shadow, expected outputs
  logic [10:0] hist[$];
  int          m_code [D];
  bit          m_err  [D];
  bit          m_mask [D];
  bit          m_valid, m_overrun;
  logic [4*D-1:0] m_digits;
  logic [D-1:0]   m_derr;

  function automatic void model_reset();
    hist.delete();
    hist.push_back('0);
    for (int i = 0; i < D; i++) begin
      m_code[i] = 0; m_err[i] = 0; m_mask[i] = 0;
    end
    m_valid = 0; m_overrun = 0; m_digits = '0; m_derr = '0;
  endfunction

  function automatic void lookup(input logic [6:0] sg, output int c, output bit e);
    c = 14; e = 1;
    if (sg == 7'h7F) begin c = 15; e = 0; end
    for (int k = 0; k < 10; k++)
      if (glyph[k] == sg) begin c = k; e = 0; end
  endfunction

  // A capture happens when exactly the last S+1 samples are identical.
  function automatic bit run_equal(input int len);
    int n = hist.size();
    if (n < len) return 0;
    for (int k = n - len; k < n; k++)
      if (hist[k] != hist[n-1]) return 0;
    return 1;
  endfunction

  function automatic void model_edge(input logic [D-1:0] an, input logic [6:0] sg,
                                     input logic rdy, input logic rst);
    bit cap, all;
    int idx, c, nlow;
    bit e;
    if (!rst) begin
      model_reset();
      return;
    end
    hist.push_back({an, sg});
    while (hist.size() > S + 2) void'(hist.pop_front());
    nlow = 0; idx = 0;
    for (int i = 0; i < D; i++) if (!an[i]) begin nlow++; idx = i; end
    cap = run_equal(S + 1) && !run_equal(S + 2) && (nlow == 1);
    all = 0;
    if (cap) begin
      lookup(sg, c, e);
      m_code[idx] = c; m_err[idx] = e; m_mask[idx] = 1;
      all = 1;
      for (int i = 0; i < D; i++) all = all && m_mask[i];
    end
    if (all) begin
      if (!m_valid || rdy) begin
        for (int i = 0; i < D; i++) begin
          m_digits[4*i +: 4] = 4'(m_code[i]);
          m_derr[i] = m_err[i];
        end
        m_valid = 1;
      end else begin
        m_overrun = 1;
      end
      for (int i = 0; i < D; i++) m_mask[i] = 0;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  bit saw_valid;

  task automatic step(input logic [D-1:0] an, input logic [6:0] sg, input logic rdy,
                      input logic rst);
    an_in = an; seg_in = sg; out_ready = rdy; rst_n = rst;
    @(posedge clk);
    model_edge(an, sg, rdy, rst);
    #1;
    if (out_valid) saw_valid = 1;
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("overrun",    32'(overrun),    32'(m_overrun));
    chk("digits_out", 32'(digits_out), 32'(m_digits));
    chk("digit_err",  32'(digit_err),  32'(m_derr));
  endtask

  task automatic hold(input logic [D-1:0] an, input logic [6:0] sg, input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(an, sg, rdy, 1'b1);
  endtask

  function automatic logic [D-1:0] strobe(input int i);
    return ~(D'(1) << i);
  endfunction

  initial begin
    model_reset();
    saw_valid = 0;

    // Reset with random inputs
    for (int k = 0; k < 3; k++) step(D'($urandom), 7'($urandom), 1'($urandom), 1'b0);
    chk("reset_digits", 32'(digits_out), 32'h0);
    chk("reset_valid",  32'(out_valid),  32'h0);

    // Frame 1,2,3,4
    saw_valid = 0;
    for (int i = 0; i < 3; i++) hold(strobe(i), glyph[i+1], 6, 1'b1);
    chk("pre_frame_valid", 32'(saw_valid), 32'h0);
    hold(strobe(3), glyph[4], 6, 1'b1);
    chk("frame1_digits", 32'(digits_out), 32'h4321);
    chk("frame1_err",    32'(digit_err),  32'h0);
    chk("frame1_seen",   32'(saw_valid),  32'h1);

    // Glitch on digit 0, then multi-low strobe
    hold(strobe(0), glyph[8], 3, 1'b1);
    hold(strobe(0), glyph[5], 6, 1'b1);
    for (int i = 1; i < 4; i++) hold(strobe(i), glyph[i+1], 6, 1'b1);
    chk("glitch_digits", 32'(digits_out), 32'h4325);
    saw_valid = 0;
    hold(4'b1100, glyph[7], 10, 1'b1);
    chk("multilow_nocap", 32'(saw_valid), 32'h0);

    // Blank and illegal glyphs
    hold(strobe(0), glyph[1], 6, 1'b1);
    hold(strobe(1), 7'b1111111, 6, 1'b1);
    hold(strobe(2), 7'b1010101, 6, 1'b1);
    hold(strobe(3), glyph[4], 6, 1'b1);
    chk("blank_illegal_digits", 32'(digits_out), 32'h4EF1);
    chk("blank_illegal_err",    32'(digit_err),  32'h4);

    // Backpressure: second frame dropped
    for (int i = 0; i < 4; i++) hold(strobe(i), glyph[i+1], 6, 1'b0);
    for (int i = 0; i < 4; i++) hold(strobe(i), glyph[i+5], 6, 1'b0);
    chk("bp_digits",  32'(digits_out), 32'h4321);
    chk("bp_overrun", 32'(overrun),    32'h1);
    chk("bp_valid",   32'(out_valid),  32'h1);
    step('1, 7'h7F, 1'b1, 1'b1);
    chk("bp_drain_valid",   32'(out_valid), 32'h0);
    chk("bp_drain_overrun", 32'(overrun),   32'h1);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) hold(strobe(i), glyph[i+6], 6, 1'b1);
    step(D'($urandom), 7'($urandom), 1'b1, 1'b0);
    chk("midreset_overrun", 32'(overrun), 32'h0);
    saw_valid = 0;
    hold(strobe(3), glyph[9], 6, 1'b1);
    chk("midreset_partial", 32'(saw_valid), 32'h0);
    for (int i = 0; i < 4; i++) hold(strobe(i), glyph[i+6], 6, 1'b1);
    chk("midreset_rescan_seen", 32'(saw_valid), 32'h1);
    chk("midreset_rescan_digits", 32'(digits_out), 32'h9876);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      int g, len;
      logic [D-1:0] an;
      logic [6:0] sg;
      g = $urandom_range(0, 11);
      sg = (g < 10) ? glyph[g] : (g == 10) ? 7'h7F : 7'($urandom);
      an = ($urandom_range(0, 7) == 0) ? D'($urandom) : strobe($urandom_range(0, D-1));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 59) == 0)
        step(an, sg, 1'b1, 1'b0);
      for (int k = 0; k < len; k++) step(an, sg, 1'($urandom_range(0, 2) != 0), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
